// File: rtl/rk_scaler.sv
// rk_scaler: source frame store read back with integer pixel replication.
// Define RK_SCALER_BORDER_EN to drive the border colour outside the image.
module rk_scaler #(
  parameter int SRC_W         = 408,
  parameter int SRC_H         = 300,
  parameter int PIX_BITS      = 1,
  parameter int HSCALE        = 2,
  parameter int VSCALE        = 2,
  parameter int SRC_LINE_SKIP = 1,
  parameter int OUT_W         = 816,
  parameter int OUT_H         = 600
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                src_ce,
  input  logic                src_frame,
  input  logic                src_line,
  input  logic                src_de,
  input  logic [PIX_BITS-1:0] src_pix,
  input  logic [10:0]         out_x,
  input  logic [10:0]         out_y,
  input  logic                out_de,
  input  logic [PIX_BITS-1:0] border,
  output logic [PIX_BITS-1:0] pix_out,
  output logic                out_de_d,
  output logic                frame_ok
);

  localparam int DEPTH = SRC_W * SRC_H;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int XW    = $clog2(SRC_W + 1);
  localparam int YW    = $clog2(SRC_H + 1);
  localparam int SKW   = (SRC_LINE_SKIP > 0) ? $clog2(SRC_LINE_SKIP + 1) : 1;
  localparam int X0    = (OUT_W - SRC_W * HSCALE) / 2;
  localparam int Y0    = (OUT_H - SRC_H * VSCALE) / 2;

  localparam logic [11:0] LX0 = 12'(X0);
  localparam logic [11:0] LY0 = 12'(Y0);
  localparam logic [11:0] LXN = 12'(SRC_W * HSCALE);
  localparam logic [11:0] LYN = 12'(SRC_H * VSCALE);

  logic [PIX_BITS-1:0] r_mem [DEPTH];
  logic [PIX_BITS-1:0] r_rdata;

  logic           r_armed;
  logic [XW-1:0]  r_wx;
  logic [YW-1:0]  r_wy;
  logic [SKW-1:0] r_skip;
  logic           r_lw;
  logic           r_frame_ok;
  logic           w_we;
  logic [AW-1:0]  w_waddr;

  assign w_we = src_ce & ~src_frame & ~src_line & src_de & r_armed
              & (r_skip == '0)
              & (r_wx < XW'(SRC_W))
              & (r_wy < YW'(SRC_H));
  assign w_waddr = AW'(r_wy) * AW'(SRC_W) + AW'(r_wx);

  // src_frame wins over src_line; pixels only on plain data cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_armed    <= 1'b0;
      r_wx       <= '0;
      r_wy       <= '0;
      r_skip     <= '0;
      r_lw       <= 1'b0;
      r_frame_ok <= 1'b0;
    end else if (src_ce) begin
      if (src_frame) begin
        if (r_wy == YW'(SRC_H))
          r_frame_ok <= 1'b1;
        r_armed <= 1'b1;
        r_wx    <= '0;
        r_wy    <= '0;
        r_skip  <= '0;
        r_lw    <= 1'b0;
      end else if (src_line) begin
        if (r_skip == '0 && r_lw)
          r_wy <= r_wy + YW'(1);
        r_skip <= (r_skip == SKW'(SRC_LINE_SKIP)) ? '0 : r_skip + SKW'(1);
        r_wx   <= '0;
        r_lw   <= 1'b0;
      end else if (w_we) begin
        r_wx <= r_wx + XW'(1);
        r_lw <= 1'b1;
      end
    end
  end

  logic [11:0]   w_ox;
  logic [11:0]   w_oy;
  logic          w_inx;
  logic          w_iny;
  logic [XW-1:0] r_rx;
  logic [XW-1:0] w_rx;
  logic [1:0]    r_hc;
  logic [1:0]    w_hc;
  logic [YW-1:0] r_ry;
  logic [YW-1:0] w_ry;
  logic [1:0]    r_vc;
  logic [1:0]    w_vc;
  logic [10:0]   r_yprev;

  assign w_ox  = {1'b0, out_x};
  assign w_oy  = {1'b0, out_y};
  assign w_inx = (w_ox - LX0) < LXN;
  assign w_iny = (w_oy - LY0) < LYN;

  always_comb begin
    w_rx = r_rx;
    w_hc = r_hc;
    if (w_ox == LX0) begin
      w_rx = '0;
      w_hc = '0;
    end else if (w_inx) begin
      if (r_hc == 2'(HSCALE - 1)) begin
        w_hc = '0;
        w_rx = r_rx + XW'(1);
      end else begin
        w_hc = r_hc + 2'd1;
      end
    end
  end

  // rows advance once per change of out_y
  always_comb begin
    w_ry = r_ry;
    w_vc = r_vc;
    if (w_oy == LY0) begin
      w_ry = '0;
      w_vc = '0;
    end else if (w_iny && out_y != r_yprev) begin
      if (r_vc == 2'(VSCALE - 1)) begin
        w_vc = '0;
        w_ry = r_ry + YW'(1);
      end else begin
        w_vc = r_vc + 2'd1;
      end
    end
  end

  logic [AW-1:0] r_raddr;
  logic          r_win1;
  logic          r_de1;
  logic          r_win2;
  logic          r_de2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx    <= '0;
      r_hc    <= '0;
      r_ry    <= '0;
      r_vc    <= '0;
      r_yprev <= '0;
      r_raddr <= '0;
      r_win1  <= 1'b0;
      r_de1   <= 1'b0;
      r_win2  <= 1'b0;
      r_de2   <= 1'b0;
    end else begin
      r_rx    <= w_rx;
      r_hc    <= w_hc;
      r_ry    <= w_ry;
      r_vc    <= w_vc;
      r_yprev <= out_y;
      r_raddr <= (w_inx && w_iny)
               ? AW'(w_ry) * AW'(SRC_W) + AW'(w_rx) : '0;
      r_win1  <= w_inx & w_iny;
      r_de1   <= out_de;
      r_win2  <= r_win1;
      r_de2   <= r_de1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we)
      r_mem[w_waddr] <= src_pix;
    r_rdata <= r_mem[r_raddr];
  end

  logic [PIX_BITS-1:0] w_bg;
`ifdef RK_SCALER_BORDER_EN
  assign w_bg = border;
`else
  logic w_unused_border;
  assign w_unused_border = ^border;
  assign w_bg = '0;
`endif

  always_comb begin
    pix_out = '0;
    if (r_de2)
      pix_out = r_win2 ? r_rdata : w_bg;
  end

  assign out_de_d = r_de2;
  assign frame_ok = r_frame_ok;

endmodule

// File: tb/tb_rk_scaler.sv
// tb_rk_scaler: random source frames and output scans against a frame model.
// Pipeline outputs are compared each cycle; model pinned by literal checks.
module tb_rk_scaler;

  localparam int SW = 8;
  localparam int SH = 6;
  localparam int PB = 2;
  localparam int HS = 2;
  localparam int VS = 2;
  localparam int SK = 1;
  localparam int OW = 20;
  localparam int OH = 16;
  localparam int X0 = (OW - SW * HS) / 2;
  localparam int Y0 = (OH - SH * VS) / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic          src_ce = 1'b0;
  logic          src_frame = 1'b0;
  logic          src_line = 1'b0;
  logic          src_de = 1'b0;
  logic [PB-1:0] src_pix = '0;
  logic [10:0]   out_x = '0;
  logic [10:0]   out_y = '0;
  logic          out_de = 1'b0;
  logic [PB-1:0] border = 2'b10;
  logic [PB-1:0] pix_out;
  logic          out_de_d;
  logic          frame_ok;

  rk_scaler #(
    .SRC_W(SW), .SRC_H(SH), .PIX_BITS(PB), .HSCALE(HS), .VSCALE(VS),
    .SRC_LINE_SKIP(SK), .OUT_W(OW), .OUT_H(OH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .src_ce(src_ce),
    .src_frame(src_frame), .src_line(src_line), .src_de(src_de),
    .src_pix(src_pix), .out_x(out_x), .out_y(out_y), .out_de(out_de),
    .border(border), .pix_out(pix_out), .out_de_d(out_de_d),
    .frame_ok(frame_ok)
  );

  typedef struct {
    bit            de;
    bit            known;
    logic [PB-1:0] pix;
    bit            fok;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  logic [PB-1:0] m_mem [SW*SH];
  bit            m_known [SW*SH];
  bit m_armed, m_lw, m_fok;
  int m_wx, m_wy, m_skip;

  int  cur_ox = 0, cur_oy = 0;
  bit  cur_ode = 1'b0, cur_rn = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, want, $time);
    end
  endtask

  function automatic logic [PB-1:0] bg();
`ifdef RK_SCALER_BORDER_EN
    return border;
`else
    return '0;
`endif
  endfunction

  function automatic void model_reset();
    m_armed = 0; m_lw = 0; m_fok = 0;
    m_wx = 0; m_wy = 0; m_skip = 0;
  endfunction

  function automatic void model_src(bit ce, bit fr, bit ln, bit de,
                                    logic [PB-1:0] px);
    if (!ce) return;
    if (fr) begin
      if (m_wy == SH) m_fok = 1;
      m_wx = 0; m_wy = 0; m_skip = 0; m_armed = 1; m_lw = 0;
    end else if (ln) begin
      if (m_skip == 0 && m_lw) m_wy++;
      m_skip = (m_skip + 1) % (SK + 1);
      m_wx = 0; m_lw = 0;
    end else if (de && m_armed && m_skip == 0 && m_wx < SW && m_wy < SH) begin
      m_mem[m_wy * SW + m_wx] = px;
      m_known[m_wy * SW + m_wx] = 1;
      m_wx++;
      m_lw = 1;
    end
  endfunction

  function automatic exp_t model_out(int x, int y, bit de);
    exp_t e;
    int a;
    e.de = de; e.known = 1; e.fok = m_fok; e.pix = '0;
    if (de) begin
      if (x >= X0 && x < X0 + SW * HS && y >= Y0 && y < Y0 + SH * VS) begin
        a = ((y - Y0) / VS) * SW + (x - X0) / HS;
        e.known = m_known[a];
        e.pix = m_mem[a];
      end else begin
        e.pix = bg();
      end
    end
    return e;
  endfunction

  task automatic step(input bit ce, input bit fr, input bit ln,
                      input bit de, input logic [PB-1:0] px);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n = cur_rn;
    src_ce = ce; src_frame = fr; src_line = ln; src_de = de; src_pix = px;
    out_x = 11'(cur_ox); out_y = 11'(cur_oy); out_de = cur_ode;
    if (!cur_rn) model_reset();
    else model_src(ce, fr, ln, de, px);
    e = model_out(cur_ox, cur_oy, cur_ode);
    e.fok = m_fok;
    q.push_back(e);
  endtask

  task automatic junk();
    step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), PB'($urandom));
  endtask

  task automatic idle(input int n);
    cur_ode = 0;
    for (int i = 0; i < n; i++) junk();
  endtask

  task automatic frame_start();
    step(1'b1, 1'b1, 1'b1, 1'b0, '0);
  endtask

  // mode 0 random, 1 {line bit, x bit}, 2 all ones
  task automatic line_px(input int n, input int mode, input int lid);
    logic [PB-1:0] v;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) junk();
      case (mode)
        1: v = {1'(lid), 1'(i)};
        2: v = '1;
        default: v = PB'($urandom);
      endcase
      step(1'b1, 1'b0, 1'b0, 1'b1, v);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic scan();
    for (int y = 0; y < OH; y++)
      for (int x = 0; x < OW + 4; x++) begin
        cur_ox = x; cur_oy = y; cur_ode = (x < OW);
        junk();
      end
    cur_ox = OW + 1;
    idle(4);
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit fk;
    if (q.size() >= 3) begin
      e = q.pop_front();
      fk = q[0].fok;
      if (reset_n) begin
        chk("out_de_d", 32'(out_de_d), 32'(e.de));
        if (e.known) chk("pix_out", 32'(pix_out), 32'(e.pix));
        chk("frame_ok", 32'(frame_ok), 32'(fk));
      end
    end
  end

  initial begin
    exp_t e;
    model_reset();
    cur_rn = 0;
    idle(3);
    cur_rn = 1;
    idle(4);
    chk("rst_frame_ok", 32'(frame_ok), 32'd0);
    chk("rst_de_d", 32'(out_de_d), 32'd0);
    chk("rst_pix", 32'(pix_out), 32'd0);
    scan();

    // frame A: stored lines {line, x[0]}, skipped lines all ones
    frame_start();
    for (int l = 0; l < 2 * SH; l++)
      line_px(SW, (l % 2) ? 2 : 1, l / 2);
    idle(4);
    chk("model_wy", 32'(m_wy), 32'd6);
    chk("model_line1", 32'(m_mem[8]), 32'd2);
    e = model_out(2, 2, 1);  chk("model_o00", 32'(e.pix), 32'd0);
    e = model_out(4, 2, 1);  chk("model_o10", 32'(e.pix), 32'd1);
    e = model_out(3, 4, 1);  chk("model_o01", 32'(e.pix), 32'd2);
    e = model_out(17, 13, 1); chk("model_o75", 32'(e.pix), 32'd3);
    e = model_out(1, 2, 0);  chk("model_nde", 32'(e.pix), 32'd0);
    chk("fok_before", 32'(frame_ok), 32'd0);
    scan();

    // frame B: random line lengths, including over-long and empty lines
    frame_start();
    idle(2);
    chk("fok_set", 32'(frame_ok), 32'd1);
    line_px(11, 0, 0);
    for (int l = 0; l < $urandom_range(9, 13); l++)
      line_px($urandom_range(0, 12), 0, 0);
    idle(4);
    scan();

    // frame C broken by reset; writes stay off until next frame
    frame_start();
    for (int l = 0; l < 4; l++) line_px(SW, 0, 0);
    cur_rn = 0;
    idle(3);
    cur_rn = 1;
    idle(2);
    for (int l = 0; l < 6; l++) line_px(SW, 0, 0);
    idle(4);
    chk("fok_after_rst", 32'(frame_ok), 32'd0);
    scan();

    frame_start();
    for (int l = 0; l < 2 * SH; l++) line_px(SW, 0, 0);
    idle(2);
    chk("fok_pre_frame", 32'(frame_ok), 32'd0);
    frame_start();
    idle(2);
    chk("fok_full", 32'(frame_ok), 32'd1);
    for (int l = 0; l < 3; l++) line_px($urandom_range(1, SW), 0, 0);
    idle(4);
    scan();
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
